// File: rtl/decode_stage_pkg.sv
// Shared decode types: instruction formats, opcodes and the decoded payload.
package decode_stage_pkg;

  typedef enum logic [2:0] {
    FMT_R    = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_NONE = 3'd6
  } fmt_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    fmt_e       fmt;
    logic       rd_we;
    logic       is_sys;
    logic       illegal;
  } dec_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] op);
    fmt_e f;
    case (op)
      OPCODE_OP:                                  f = FMT_R;
      OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR,
      OPCODE_FENCE, OPCODE_SYSTEM:                f = FMT_I;
      OPCODE_STORE:                               f = FMT_S;
      OPCODE_BRANCH:                              f = FMT_B;
      OPCODE_LUI, OPCODE_AUIPC:                   f = FMT_U;
      OPCODE_JAL:                                 f = FMT_J;
      default:                                    f = FMT_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// IF-side and EX-side handshake bundle of the decode stage.
interface decode_stage_if #(
  parameter int unsigned XLEN = 32
);
  import decode_stage_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [31:0]     in_instr;

  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1_addr;
  logic [4:0]      out_rs2_addr;
  logic [4:0]      out_rd_addr;
  logic [6:0]      out_opcode;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  fmt_e            out_fmt;
  logic [XLEN-1:0] out_imm;
  logic            out_rd_we;
  logic            out_is_sys;
  logic            out_illegal;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_addr, out_rs2_addr, out_rd_addr,
           out_opcode, out_funct3, out_funct7, out_fmt, out_imm, out_rd_we,
           out_is_sys, out_illegal
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_addr, out_rs2_addr, out_rd_addr,
           out_opcode, out_funct3, out_funct7, out_fmt, out_imm, out_rd_we,
           out_is_sys, out_illegal
  );

endinterface

// File: rtl/decode_stage_core.sv
// Pure combinational RV instruction decoder: raw instruction -> dec_t + immediate.
module decode_core
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output dec_t            dec_o,
  output logic [XLEN-1:0] imm_o
);

  fmt_e raw_fmt;
  fmt_e fmt;
  logic illegal;
  logic op_bad;

  always_comb begin
    raw_fmt = opcode_fmt(instr_i[6:0]);
    op_bad  = (instr_i[6:0] == OPCODE_OP) &&
              (!(instr_i[31:25] inside {7'h00, 7'h20}) ||
               ((instr_i[31:25] == 7'h20) && !(instr_i[14:12] inside {3'd0, 3'd5})));
    illegal = (instr_i[1:0] != 2'b11) || (instr_i == '0) || (instr_i == '1) ||
              (raw_fmt == FMT_NONE) || op_bad;
    fmt     = illegal ? FMT_NONE : raw_fmt;

    dec_o         = '0;
    dec_o.rs1     = instr_i[19:15];
    dec_o.rs2     = instr_i[24:20];
    dec_o.rd      = instr_i[11:7];
    dec_o.opcode  = instr_i[6:0];
    dec_o.funct3  = instr_i[14:12];
    dec_o.funct7  = instr_i[31:25];
    dec_o.fmt     = fmt;
    dec_o.rd_we   = (fmt inside {FMT_R, FMT_I, FMT_U, FMT_J}) && (instr_i[11:7] != 5'd0);
    dec_o.is_sys  = instr_i[6:0] inside {OPCODE_FENCE, OPCODE_SYSTEM};
    dec_o.illegal = illegal;

    // Size casts of signed values sign-extend from instr[31] to XLEN.
    case (fmt)
      FMT_I:   imm_o = XLEN'($signed(instr_i[31:20]));
      FMT_S:   imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      FMT_B:   imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                      instr_i[11:8], 1'b0}));
      FMT_U:   imm_o = XLEN'($signed({instr_i[31:12], 12'b0}));
      FMT_J:   imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                      instr_i[30:21], 1'b0}));
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: valid/ready handshake, optional 1-entry skid buffer, flush.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           flush,
  decode_stage_if.slave bus
);

  if ((XLEN != 32) && (XLEN != 64)) begin : g_xlen_chk
    $error("decode_stage: XLEN must be 32 or 64");
  end

  logic            out_valid_q, out_valid_d;
  logic            skid_valid_q, skid_valid_d;
  logic            in_ready_q, in_ready_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] imm_q, imm_d;
  dec_t            dec_q, dec_d;

  logic            in_ready;
  logic            in_fire;
  logic            out_free;
  logic            use_skid;
  logic            load_out;
  logic [31:0]     src_instr;
  logic [XLEN-1:0] src_pc;
  logic [XLEN-1:0] src_imm;
  dec_t            src_dec;

  assign in_ready = SKID_EN ? in_ready_q : (!out_valid_q || bus.out_ready);

  decode_core #(.XLEN(XLEN)) u_core (
    .instr_i (src_instr),
    .dec_o   (src_dec),
    .imm_o   (src_imm)
  );

  always_comb begin
    in_fire   = bus.in_valid && in_ready;
    out_free  = !out_valid_q || bus.out_ready;
    use_skid  = SKID_EN && skid_valid_q;
    src_instr = use_skid ? skid_instr_q : bus.in_instr;
    src_pc    = use_skid ? skid_pc_q : bus.in_pc;

    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    load_out     = 1'b0;

    // The skid always drains ahead of the input so beat order is preserved.
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      load_out     = use_skid || in_fire;
      out_valid_d  = use_skid || in_fire;
      skid_valid_d = use_skid && in_fire;
    end else if (in_fire) begin
      skid_valid_d = SKID_EN;
    end

    if (in_fire) begin
      skid_instr_d = bus.in_instr;
      skid_pc_d    = bus.in_pc;
    end

    pc_d       = load_out ? src_pc  : pc_q;
    imm_d      = load_out ? src_imm : imm_q;
    dec_d      = load_out ? src_dec : dec_q;
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      dec_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      pc_q         <= pc_d;
      imm_q        <= imm_d;
      dec_q        <= dec_d;
    end
  end

  assign bus.in_ready     = in_ready;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_pc       = pc_q;
  assign bus.out_rs1_addr = dec_q.rs1;
  assign bus.out_rs2_addr = dec_q.rs2;
  assign bus.out_rd_addr  = dec_q.rd;
  assign bus.out_opcode   = dec_q.opcode;
  assign bus.out_funct3   = dec_q.funct3;
  assign bus.out_funct7   = dec_q.funct7;
  assign bus.out_fmt      = dec_q.fmt;
  assign bus.out_imm      = imm_q;
  assign bus.out_rd_we    = dec_q.rd_we;
  assign bus.out_is_sys   = dec_q.is_sys;
  assign bus.out_illegal  = dec_q.illegal;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered instruction-decode pipeline stage between IF and EX.
- Accepts (pc, instruction) beats on a valid/ready handshake and emits a fully decoded, XLEN-wide bundle one cycle later.
- Generalises the combinational decoder in four ways: XLEN-parametrised immediates, FENCE/SYSTEM support, illegal-instruction detection, and a flushable, back-pressure-tolerant skid buffer so IF never loses a beat.

Parameters:
- XLEN, 32, datapath/immediate width; legal values are 32 or 64 (any other value triggers an elaboration $error).
- SKID_EN, 1, when 1 a 1-entry skid buffer is instantiated and in_ready is a register output; when 0, in_ready = !out_valid || out_ready (combinational).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  kill all held and in-flight beats (branch mispredict/trap).
- in_valid  in  1  IF beat valid.
- in_ready  out  1  stage can accept a beat.
- in_pc  in  XLEN  PC of the instruction.
- in_instr  in  32  raw instruction.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  EX accepts the beat.
- out_pc  out  XLEN  registered PC.
- out_rs1_addr, out_rs2_addr, out_rd_addr  out  5 each  register indices.
- out_opcode  out  7;  out_funct3  out  3;  out_funct7  out  7  raw fields.
- out_fmt  out  3  fmt_e: FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE.
- out_imm  out  XLEN  sign-extended immediate.
- out_rd_we  out  1  instruction writes rd, and rd != 0.
- out_is_sys  out  1  opcode is FENCE or SYSTEM.
- out_illegal  out  1  instruction is illegal.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - out_valid=0, skid valid=0, all payload outputs=0.
  - in_ready=1 when SKID_EN=1.
- Latency: a beat accepted at edge N (in_valid && in_ready) appears on out_* after edge N, i.e. a 1-cycle latency; no bubble when out_ready is held at 1.
- Immediates, each sign-extended from instr[31] to XLEN:
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}; for XLEN=64 bits 63:32 = instr[31].
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and FMT_NONE: imm=0.
- Format map:
  - OP → R.
  - LOAD, OP-IMM, JALR, FENCE, SYSTEM → I.
  - STORE → S.
  - BRANCH → B.
  - LUI, AUIPC → U.
  - JAL → J.
  - Anything else → FMT_NONE.
- out_rd_we=1 for R, I, U, J formats with rd != 0; 0 for S, B and illegal.
- out_illegal=1 for any of:
  - instr[1:0] != 2'b11;
  - instr == 0 or instr == 32'hFFFF_FFFF;
  - fmt == FMT_NONE;
  - OP with funct7 ∉ {7'h00, 7'h20};
  - OP with funct7 == 7'h20 and funct3 ∉ {0, 5}.
- Illegal beats are still forwarded in order with out_fmt=FMT_NONE, out_imm=0 and out_rd_we=0; trapping belongs to EX.
- Handshake:
  - A beat is held stable on out_* while out_valid && !out_ready.
  - The output register loads from the skid buffer if it is valid, otherwise from the input.
- Skid buffer (SKID_EN=1):
  - Captures the input when the input fires while out_valid && !out_ready.
  - in_ready deasserts the cycle after the skid fills.
  - Simultaneous out fire and in fire: skid → out, input → skid, or input → out if the skid is empty.
  - Beat order is strictly preserved; no beat is dropped or duplicated.
- flush:
  - Takes priority over every other event.
  - On the next edge: out_valid=0, skid valid=0; any input firing in the same cycle is discarded.
  - in_ready=1 in the cycle after the flush edge.
- Reset asserted mid-transfer: all beats are lost and state returns to reset values immediately (async).

Decomposition:
- Shared package (risc_pkg) additions:
  - fmt_e enum (3 bits);
  - OPCODE_FENCE (7'b0001111) and OPCODE_SYSTEM (7'b1110011);
  - dec_t packed struct holding the decoded payload.
- Sub-module decode_core, parametrised by XLEN: pure combinational instr → dec_t, also reused by a future pre-decoder.
- decode_stage holds only the handshake, skid buffer and output registers.

Test Plan:
- XLEN=32, 0xFFF00093 (addi x1,x0,-1) → one cycle later out_fmt=FMT_I, out_rd_addr=1, out_imm=0xFFFFFFFF, out_rd_we=1, out_illegal=0.
- 0x00112223 (sw x1,4(x2)) → out_fmt=FMT_S, out_rs1_addr=2, out_rs2_addr=1, out_imm=4, out_rd_we=0.
- XLEN=64, 0x800000B7 (lui x1,0x80000) → out_imm=0xFFFFFFFF80000000, out_fmt=FMT_U.
- Back-pressure: 4 back-to-back beats with out_ready=0 for 3 cycles → in_ready drops after the 2nd beat held; all 4 beats emerge in order with no duplicates; with SKID_EN=0 there is no loss either.
- Illegal inputs 0x00000000, 0xFFFFFFFF, 0x0000007F and 0x40001033 (funct7=0x20, funct3=1) → each beat forwarded with out_illegal=1, out_fmt=FMT_NONE, out_imm=0.
- Flush with out_valid=1, skid full and in_valid=1 → after the next edge out_valid=0, the skid is empty and the input is dropped; the next beat is accepted the following cycle. Repeat the scenario with an async rst_n pulse instead of flush → outputs return to zero immediately.
